// File: rtl/lab6_pkg.sv
// lab6_pkg
//    Shared definitions for the lab6 sample feeder slice: default sample
//    width, completed-sample counter width and the feeder FSM encoding.
//    Ports: none (package).
package lab6_pkg;

   localparam int DATA_W = 10;
   localparam int CNT_W  = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ISSUE   = 2'b01,
      WAIT_LO = 2'b10,
      WAIT_HI = 2'b11
   } state_t;

   // True while the datapath owns the current sample and the watchdog runs.
   function automatic logic is_waiting(input state_t s);
      return (s == WAIT_LO) || (s == WAIT_HI);
   endfunction

endpackage

// File: rtl/lab6_sync_fifo.sv
// lab6_sync_fifo
//    Single-clock FIFO holding samples waiting for the datapath. The head
//    entry is presented continuously and only moves when it is popped.
//    Ports:
//       clk    in   rising-edge clock
//       reset  in   synchronous, active-low clear of pointers and occupancy
//       push   in   write data into the tail (ignored while full)
//       pop    in   drop the head entry (ignored while empty)
//       data   in   DATA_W  sample to store
//       head   out  DATA_W  oldest stored sample
//       level  out  $clog2(DEPTH)+1  number of stored samples
//       full   out  level == DEPTH
//       empty  out  level == 0
module lab6_sync_fifo #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = lab6_pkg::DATA_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [DATA_W-1:0]      data,
   output logic [DATA_W-1:0]      head,
   output logic [$clog2(DEPTH):0] level,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              push_ok;
   logic              pop_ok;

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign full    = (level == FULL_LEVEL);
   assign empty   = (level == '0);
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping. DEPTH is a power of two so the
   // pointers wrap for free; a simultaneous push and pop leaves level alone.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop_ok)      level <= level + 1'b1;
         else if (pop_ok && !push_ok) level <= level - 1'b1;
      end
   end

   // Storage array. Contents are not cleared on reset; an empty FIFO never
   // exposes stale entries as valid data.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= data;
   end

endmodule

// File: rtl/lab6_sample_feeder.sv
// lab6_sample_feeder
//    Buffers incoming samples and hands them one at a time to the lab6 3-tap
//    filter datapath over its irdy/din/ordy handshake. din stays on the FIFO
//    head for the whole computation; the head is popped only when the
//    datapath answers with ordy. A watchdog drops the sample and raises a
//    sticky error if the datapath never answers.
//    Ports:
//       clk         in   rising-edge clock
//       reset       in   synchronous, active-low
//       s_data      in   DATA_W  incoming sample
//       s_valid     in   s_data valid, accepted when s_ready is high
//       s_ready     out  FIFO not full
//       irdy        out  one-cycle request to the datapath
//       din         out  DATA_W  sample presented to the datapath (FIFO head)
//       ordy        in   datapath result-ready level
//       done        out  one-cycle pulse, datapath result valid this cycle
//       level       out  FIFO occupancy
//       err         out  sticky watchdog error
//       sample_cnt  out  completed samples, wraps silently
module lab6_sample_feeder #(
   parameter int DATA_W  = lab6_pkg::DATA_W,
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 15
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [DATA_W-1:0]          s_data,
   input  logic                       s_valid,
   output logic                       s_ready,
   output logic                       irdy,
   output logic [DATA_W-1:0]          din,
   input  logic                       ordy,
   output logic                       done,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       err,
   output logic [lab6_pkg::CNT_W-1:0] sample_cnt
);

   import lab6_pkg::*;

   localparam int LW = $clog2(DEPTH) + 1;
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT);

   state_t          state;
   state_t          next_state;
   logic            push;
   logic            pop;
   logic            full;
   logic            empty;
   logic            abort;
   logic [WW-1:0]   watchdog;
   logic [WW-1:0]   wd_next;

   assign s_ready = !full;
   assign push    = s_valid && s_ready;
   assign irdy    = (state == ISSUE);
   assign wd_next = watchdog + 1'b1;

   lab6_sync_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .data  (s_data),
      .head  (din),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   // Next-state and handshake decode. The watchdog compares its incremented
   // value so the abort lands at the end of the TIMEOUT-th waiting cycle and
   // err is visible exactly TIMEOUT+1 cycles after irdy. A real answer in
   // WAIT_HI wins over a timeout in the same cycle. Any ordy seen in IDLE or
   // ISSUE is simply not looked at.
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      done       = 1'b0;
      abort      = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) next_state = ISSUE;
         end
         ISSUE: begin
            next_state = WAIT_LO;
         end
         WAIT_LO: begin
            if (wd_next == WD_LIMIT) abort = 1'b1;
            else if (!ordy)          next_state = WAIT_HI;
         end
         WAIT_HI: begin
            if (ordy) begin
               done       = 1'b1;
               pop        = 1'b1;
               next_state = (level > LW'(1)) ? ISSUE : IDLE;
            end else if (wd_next == WD_LIMIT) begin
               abort = 1'b1;
            end
         end
      endcase
      if (abort) begin
         pop        = 1'b1;
         next_state = IDLE;
      end
   end

   // State register, watchdog, sticky error and completed-sample counter.
   // The watchdog restarts on every issue and only runs while waiting.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         watchdog   <= '0;
         err        <= 1'b0;
         sample_cnt <= '0;
      end else begin
         state <= next_state;
         if (state == ISSUE)          watchdog <= '0;
         else if (is_waiting(state))  watchdog <= wd_next;
         if (abort) err <= 1'b1;
         if (done)  sample_cnt <= sample_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_lab6_sample_feeder.sv
// tb_lab6_sample_feeder
//    Bench for lab6_sample_feeder. A small behavioural stand-in for the lab6
//    datapath answers each irdy four cycles later; it can also be swapped for
//    ordy tied low or tied high. A queue-based model tracks what the feeder
//    must show every cycle, and directed literal checks pin the model.
module tb_lab6_sample_feeder;

   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 15;

   logic        clk;
   logic        reset;
   logic [9:0]  s_data;
   logic        s_valid;
   logic        s_ready;
   logic        irdy;
   logic [9:0]  din;
   logic        ordy;
   logic        done;
   logic [3:0]  level;
   logic        err;
   logic [15:0] sample_cnt;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit checkOn = 0;
   int doneCount = 0;
   int irdyLog[$];

   // datapath stand-in: mode 0 normal, 1 ordy tied low, 2 ordy tied high
   logic [1:0] dpMode;
   logic       dpOrdy;
   int         dpCnt;

   // model state
   logic [9:0]  mq[$];
   bit          mIssue, mInflight, mSeenLow, mDoneNow, mNext, mPop;
   int          mWait, mSize;
   logic [15:0] mCnt;
   bit          mErr;
   bit          expDone;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   lab6_sample_feeder #(
      .DATA_W  (10),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .irdy       (irdy),
      .din        (din),
      .ordy       (ordy),
      .done       (done),
      .level      (level),
      .err        (err),
      .sample_cnt (sample_cnt)
   );

   assign ordy = (dpMode == 2'd0) ? dpOrdy : (dpMode == 2'd2);

   // Datapath stand-in: drops ordy at the edge ending the irdy cycle and
   // raises it again so it is high four cycles after irdy.
   always @(posedge clk) begin
      if (!reset) begin
         dpOrdy <= 1'b0;
         dpCnt  <= 0;
      end else if (irdy) begin
         dpOrdy <= 1'b0;
         dpCnt  <= 1;
      end else if (dpCnt == 3) begin
         dpOrdy <= 1'b1;
         dpCnt  <= 0;
      end else if (dpCnt != 0) begin
         dpCnt <= dpCnt + 1;
      end
   end

   // Model: a queue of buffered samples plus the life of the sample in
   // flight (issue cycle, count of waiting cycles, whether the datapath has
   // dropped ordy yet). Updated from bench-driven inputs only.
   always @(posedge clk) begin
      cyc++;
      if (!reset) begin
         mq.delete();
         mIssue = 0; mInflight = 0; mSeenLow = 0; mWait = 0;
         mCnt = 16'h0000; mErr = 0;
      end else begin
         mSize    = mq.size();
         mDoneNow = mInflight && mSeenLow && ordy;
         mNext    = 0;
         mPop     = 0;
         if (mIssue) begin
            mInflight = 1; mWait = 1; mSeenLow = 0;
         end else if (mInflight) begin
            if (mDoneNow) begin
               mPop = 1; mCnt = mCnt + 16'h0001; mInflight = 0;
               mNext = (mSize > 1);
            end else if (mWait == TIMEOUT) begin
               mPop = 1; mErr = 1; mInflight = 0;
            end else begin
               if (!ordy) mSeenLow = 1;
               mWait++;
            end
         end else begin
            mNext = (mSize > 0);
         end
         mIssue = mNext;
         if (mPop) void'(mq.pop_front());
         if (s_valid && mSize < DEPTH) mq.push_back(s_data);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (checkOn) begin
         expDone = mInflight && mSeenLow && ordy;
         checkOutput("model level", 32'(level), 32'(mq.size()));
         checkOutput("model s_ready", 32'(s_ready), 32'(mq.size() < DEPTH));
         checkOutput("model irdy", 32'(irdy), 32'(mIssue));
         checkOutput("model done", 32'(done), 32'(expDone));
         checkOutput("model err", 32'(err), 32'(mErr));
         checkOutput("model sample_cnt", 32'(sample_cnt), 32'(mCnt));
         if (mq.size() > 0) checkOutput("model din", 32'(din), 32'(mq[0]));
         if (irdy === 1'b1) irdyLog.push_back(cyc);
         if (done === 1'b1) doneCount++;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Present one sample and hold it until accepted; reports stalled cycles.
   task automatic applyStimulus(input logic [9:0] d, output int stall);
      s_valid = 1'b1;
      s_data  = d;
      stall   = 0;
      while (!s_ready && stall < 50) begin
         step();
         stall++;
      end
      step();
      s_valid = 1'b0;
   endtask

   task automatic waitIrdy(input string name);
      int n = 0;
      while (irdy !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      checkOutput(name, 32'(irdy), 32'd1);
   endtask

   initial begin
      int stall;
      reset   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      dpMode  = 2'd0;
      repeat (3) @(posedge clk);
      #2;
      reset   = 1'b1;
      checkOn = 1;

      // reset state
      checkOutput("reset level", 32'(level), 32'd0);
      checkOutput("reset s_ready", 32'(s_ready), 32'd1);
      checkOutput("reset irdy", 32'(irdy), 32'd0);
      checkOutput("reset err", 32'(err), 32'd0);
      checkOutput("reset sample_cnt", 32'(sample_cnt), 32'd0);
      step();

      // single sample into an empty FIFO
      s_valid = 1'b1;
      s_data  = 10'h100;
      step();
      s_valid = 1'b0;
      checkOutput("t1 level after push", 32'(level), 32'd1);
      checkOutput("t1 no irdy yet", 32'(irdy), 32'd0);
      step();
      checkOutput("t1 irdy", 32'(irdy), 32'd1);
      checkOutput("t1 din at irdy", 32'(din), 32'h100);
      for (int i = 0; i < 3; i++) begin
         step();
         checkOutput("t1 done early", 32'(done), 32'd0);
         checkOutput("t1 din held", 32'(din), 32'h100);
      end
      step();
      checkOutput("t1 done at irdy+4", 32'(done), 32'd1);
      checkOutput("t1 din at done", 32'(din), 32'h100);
      step();
      checkOutput("t1 sample_cnt", 32'(sample_cnt), 32'd1);
      checkOutput("t1 level drained", 32'(level), 32'd0);
      step();

      // burst of ten samples with s_valid held through the full condition
      for (int i = 0; i < 10; i++) begin
         applyStimulus(10'(i * 37 + 5), stall);
         checkOutput($sformatf("t2 stall[%0d]", i), 32'(stall), (i == 9) ? 32'd3 : 32'd0);
      end
      checkOutput("t3 level refilled", 32'(level), 32'd8);
      checkOutput("t3 s_ready full", 32'(s_ready), 32'd0);
      repeat (60) step();
      checkOutput("t2 done count", 32'(doneCount), 32'd11);
      checkOutput("t2 sample_cnt", 32'(sample_cnt), 32'd11);
      checkOutput("t2 irdy count", 32'(irdyLog.size()), 32'd11);
      for (int i = 2; i < 11 && i < irdyLog.size(); i++)
         checkOutput($sformatf("t2 irdy gap %0d", i), 32'(irdyLog[i] - irdyLog[i-1]), 32'd5);

      // watchdog with ordy tied low
      dpMode = 2'd1;
      applyStimulus(10'h3FF, stall);
      waitIrdy("t4 irdy");
      repeat (TIMEOUT) step();
      checkOutput("t4 err before limit", 32'(err), 32'd0);
      step();
      checkOutput("t4 err at limit", 32'(err), 32'd1);
      checkOutput("t4 sample dropped", 32'(level), 32'd0);
      checkOutput("t4 count unchanged", 32'(sample_cnt), 32'd11);
      repeat (5) step();
      checkOutput("t4 err sticky", 32'(err), 32'd1);
      checkOutput("t4 no done", 32'(doneCount), 32'd11);

      // ordy stuck high: no progress, watchdog drops the sample
      dpMode = 2'd2;
      applyStimulus(10'h2AA, stall);
      repeat (25) step();
      checkOutput("t7 count unchanged", 32'(sample_cnt), 32'd11);
      checkOutput("t7 sample dropped", 32'(level), 32'd0);
      checkOutput("t7 no done", 32'(doneCount), 32'd11);

      // reset while in WAIT_HI with three samples buffered
      dpMode = 2'd0;
      applyStimulus(10'h011, stall);
      applyStimulus(10'h022, stall);
      applyStimulus(10'h033, stall);
      step();
      checkOutput("t5 level before reset", 32'(level), 32'd3);
      checkOutput("t5 no done yet", 32'(done), 32'd0);
      reset = 1'b0;
      step();
      reset = 1'b1;
      checkOutput("t5 level cleared", 32'(level), 32'd0);
      checkOutput("t5 irdy cleared", 32'(irdy), 32'd0);
      checkOutput("t5 count cleared", 32'(sample_cnt), 32'd0);
      checkOutput("t5 err cleared", 32'(err), 32'd0);
      applyStimulus(10'h055, stall);
      step();
      checkOutput("t5 restart irdy", 32'(irdy), 32'd1);
      checkOutput("t5 restart din", 32'(din), 32'h055);
      repeat (4) step();
      checkOutput("t5 restart done", 32'(done), 32'd1);
      step();
      checkOutput("t5 restart count", 32'(sample_cnt), 32'd1);

      // counter wrap
      force dut.sample_cnt = 16'hFFFF;
      mCnt = 16'hFFFF;
      step();
      release dut.sample_cnt;
      applyStimulus(10'h123, stall);
      step();
      checkOutput("t6 irdy", 32'(irdy), 32'd1);
      repeat (4) step();
      checkOutput("t6 done", 32'(done), 32'd1);
      checkOutput("t6 count before wrap", 32'(sample_cnt), 32'hFFFF);
      step();
      checkOutput("t6 count wrapped", 32'(sample_cnt), 32'h0000);
      checkOutput("t6 done over", 32'(done), 32'd0);
      repeat (3) step();

      checkOn = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global timeout: got=running want=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
